// File: rtl/mul_exec_unit.sv
// Multiplier functional unit: fixed-latency low-half multiply pipeline feeding an
// in-order output FIFO that drives the CDB MUL channel, with credit back-pressure to the RS.
module mul_exec_unit #(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 5,
    parameter int REG_W      = 5,
    parameter int LATENCY    = 3,
    parameter int OBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_we,
    input  logic [REG_W-1:0]  iss_dst,
    input  logic [TAG_W-1:0]  iss_dst_tag,
    input  logic [DATA_W-1:0] iss_val1,
    input  logic [DATA_W-1:0] iss_val2,
    output logic              iss_ready,
    input  logic              cdb_grant,
    output logic              we_MUL,
    output logic [REG_W-1:0]  dst_MUL,
    output logic [TAG_W-1:0]  tag_MUL,
    output logic [DATA_W-1:0] val_MUL
);

    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
    localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  dst;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] prod;
    } stage_t;

    logic             acc;
    logic             pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    stage_t           issue_s;
    stage_t           wr_s;

    // ------------------------------------------------------------------
    // Credit counter: instructions in the pipeline plus FIFO occupancy.
    // ------------------------------------------------------------------
    assign iss_ready = (cnt < CNT_W'(OBUF_DEPTH));
    assign acc       = iss_we & iss_ready;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_next = cnt;
        case ({acc, pop})
            2'b10:   cnt_next = cnt + CNT_W'(1);
            2'b01:   cnt_next = cnt - CNT_W'(1);
            default: cnt_next = cnt;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Multiply pipeline. The full low-half product is formed on entry and
    // carried down the stages; the last stage output is the FIFO write port.
    // ------------------------------------------------------------------
    always_comb begin
        issue_s       = '0;
        issue_s.valid = acc;
        issue_s.dst   = iss_dst;
        issue_s.tag   = iss_dst_tag;
        issue_s.prod  = iss_val1 * iss_val2;
    end

    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign wr_s = issue_s;
        end else begin : g_pipe
            stage_t pipe [LATENCY-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        pipe[i].valid <= 1'b0;
                    end
                end else begin
                    pipe[0] <= issue_s;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign wr_s = pipe[LATENCY-2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output FIFO. Credits guarantee a free slot for every write.
    // ------------------------------------------------------------------
    logic [REG_W-1:0]  mem_dst [OBUF_DEPTH];
    logic [TAG_W-1:0]  mem_tag [OBUF_DEPTH];
    logic [DATA_W-1:0] mem_val [OBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = ~fifo_empty & cdb_grant;

    // NOTE: storage is deliberately not reset; occupancy is tracked by fifo_cnt and empty entries are never observed.
    always_ff @(posedge clk) begin
        if (wr_s.valid) begin
            mem_dst[wr_ptr] <= wr_s.dst;
            mem_tag[wr_ptr] <= wr_s.tag;
            mem_val[wr_ptr] <= wr_s.prod;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_s.valid) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_s.valid, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Head is presented only when valid so stale storage never reaches the CDB.
    always_comb begin
        we_MUL  = ~fifo_empty;
        dst_MUL = '0;
        tag_MUL = '0;
        val_MUL = '0;
        if (!fifo_empty) begin
            dst_MUL = mem_dst[rd_ptr];
            tag_MUL = mem_tag[rd_ptr];
            val_MUL = mem_val[rd_ptr];
        end
    end

endmodule

// File: tb/tb_mul_exec_unit.sv
// Directed self-checking bench for mul_exec_unit: latency, arithmetic corner cases,
// credit back-pressure, pointer wrap, mid-operation reset and full-FIFO accept timing.
module tb_mul_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_we;
    logic [4:0]  iss_dst;
    logic [4:0]  iss_dst_tag;
    logic [31:0] iss_val1;
    logic [31:0] iss_val2;
    logic        iss_ready;
    logic        cdb_grant;
    logic        we_MUL;
    logic [4:0]  dst_MUL;
    logic [4:0]  tag_MUL;
    logic [31:0] val_MUL;

    int checks   = 0;
    int failures = 0;

    mul_exec_unit dut (
        .clk         (clk),
        .reset       (reset),
        .iss_we      (iss_we),
        .iss_dst     (iss_dst),
        .iss_dst_tag (iss_dst_tag),
        .iss_val1    (iss_val1),
        .iss_val2    (iss_val2),
        .iss_ready   (iss_ready),
        .cdb_grant   (cdb_grant),
        .we_MUL      (we_MUL),
        .dst_MUL     (dst_MUL),
        .tag_MUL     (tag_MUL),
        .val_MUL     (val_MUL)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] dst, input logic [4:0] tag,
                         input logic [31:0] a, input logic [31:0] b, input logic g);
        iss_we      = we;
        iss_dst     = dst;
        iss_dst_tag = tag;
        iss_val1    = a;
        iss_val2    = b;
        cdb_grant   = g;
    endtask

    task automatic idle(input logic g);
        drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, g);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    int tag_q[$];
    int issued;
    int received;
    int model_cnt;
    logic g;

    initial begin
        reset = 1'b1;
        idle(1'b0);
        tick();

        // ---- Reset state ----
        do_reset();
        check("rst_we",    we_MUL,    1'b0);
        check("rst_dst",   dst_MUL,   5'd0);
        check("rst_tag",   tag_MUL,   5'd0);
        check("rst_val",   val_MUL,   32'd0);
        check("rst_ready", iss_ready, 1'b1);

        // ---- 1: single issue, result on CDB exactly in c+3 ----
        drive(1'b1, 5'd3, 5'd5, 32'd7, 32'd6, 1'b1);
        check("t1_ready_c", iss_ready, 1'b1);
        check("t1_we_c",    we_MUL,    1'b0);
        tick();
        idle(1'b1);
        check("t1_we_c1", we_MUL, 1'b0);
        tick();
        check("t1_we_c2", we_MUL, 1'b0);
        tick();
        check("t1_we_c3",  we_MUL,  1'b1);
        check("t1_val_c3", val_MUL, 32'd42);
        check("t1_dst_c3", dst_MUL, 5'd3);
        check("t1_tag_c3", tag_MUL, 5'd5);
        tick();
        check("t1_we_c4", we_MUL, 1'b0);

        // ---- 2: arithmetic corner cases, back-to-back ----
        drive(1'b1, 5'd1, 5'd6, 32'hFFFF_FFFD, 32'd5, 1'b1);
        tick();
        drive(1'b1, 5'd2, 5'd7, 32'h8000_0000, 32'd2, 1'b1);
        tick();
        drive(1'b1, 5'd4, 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        tick();
        idle(1'b1);
        check("t2_we0",  we_MUL,  1'b1);
        check("t2_val0", val_MUL, 32'hFFFF_FFF1);
        check("t2_tag0", tag_MUL, 5'd6);
        tick();
        check("t2_we1",  we_MUL,  1'b1);
        check("t2_val1", val_MUL, 32'h0000_0000);
        check("t2_tag1", tag_MUL, 5'd7);
        tick();
        check("t2_we2",  we_MUL,  1'b1);
        check("t2_val2", val_MUL, 32'h0000_0001);
        check("t2_dst2", dst_MUL, 5'd4);
        tick();
        check("t2_we3", we_MUL, 1'b0);

        // ---- 3: credits exhaust after 4 accepts; 5th issue ignored ----
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 5'(i), 32'(i), 32'd10, 1'b0);
            check($sformatf("t3_ready_issue%0d", i), iss_ready, 1'b1);
            tick();
        end
        drive(1'b1, 5'd9, 5'd9, 32'd9, 32'd9, 1'b0);
        check("t3_ready_after4", iss_ready, 1'b0);
        tick();
        idle(1'b0);
        check("t3_ready_hold", iss_ready, 1'b0);
        tick();
        idle(1'b1);
        check("t3_ready_pop0", iss_ready, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t3_we%0d", i),  we_MUL,  1'b1);
            check($sformatf("t3_tag%0d", i), tag_MUL, 5'(i));
            check($sformatf("t3_val%0d", i), val_MUL, 32'(i * 10));
            tick();
            if (i == 1) check("t3_ready_after_pop", iss_ready, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            check("t3_no_stale", we_MUL, 1'b0);
            tick();
        end

        // ---- 4: 12 issues, grant toggling, pointer wrap, ready tracks a credit model ----
        do_reset();
        issued    = 0;
        received  = 0;
        model_cnt = 0;
        tag_q.delete();
        for (int cyc = 0; cyc < 200 && received < 12; cyc++) begin
            g = ((cyc % 2) == 0);
            if (issued < 12)
                drive(1'b1, 5'd1, 5'(issued + 1), 32'(issued + 1), 32'd3, g);
            else
                idle(g);
            check("t4_ready", iss_ready, (model_cnt < 4));
            if (we_MUL && g) begin
                if (tag_q.size() == 0) begin
                    check("t4_unexpected_pop", tag_MUL, 5'd0);
                end else begin
                    check("t4_tag", tag_MUL, 5'(tag_q[0]));
                    check("t4_val", val_MUL, 32'(tag_q[0] * 3));
                    void'(tag_q.pop_front());
                end
                received++;
                model_cnt--;
            end
            if (issued < 12 && model_cnt + (we_MUL && g ? 1 : 0) < 4) begin
                tag_q.push_back(issued + 1);
                issued++;
                model_cnt++;
            end
            tick();
        end
        check("t4_received", 32'(received), 32'd12);
        idle(1'b1);
        tick();
        check("t4_drained", we_MUL, 1'b0);

        // ---- 5: reset with work in flight and in the FIFO ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd2, 5'(10 + i), 32'(i + 2), 32'd7, 1'b0);
            tick();
        end
        drive(1'b1, 5'd2, 5'd13, 32'd5, 32'd7, 1'b0);
        check("t5_pre_we",  we_MUL,  1'b1);
        check("t5_pre_tag", tag_MUL, 5'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(1'b1);
        check("t5_we",    we_MUL,    1'b0);
        check("t5_dst",   dst_MUL,   5'd0);
        check("t5_tag",   tag_MUL,   5'd0);
        check("t5_val",   val_MUL,   32'd0);
        check("t5_ready", iss_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_no_stale", we_MUL, 1'b0);
        end

        // ---- 6: FIFO full, grant and issue together -> accept only next cycle ----
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'd7, 5'(i), 32'(i), 32'd1, 1'b0);
            tick();
        end
        idle(1'b0);
        tick();
        tick();
        drive(1'b1, 5'd7, 5'd20, 32'd20, 32'd1, 1'b1);
        check("t6_ready_full", iss_ready, 1'b0);
        check("t6_we_full",    we_MUL,    1'b1);
        check("t6_tag_head",   tag_MUL,   5'd1);
        tick();
        drive(1'b1, 5'd7, 5'd21, 32'd21, 32'd1, 1'b0);
        check("t6_ready_next", iss_ready, 1'b1);
        check("t6_tag_next",   tag_MUL,   5'd2);
        tick();
        idle(1'b0);
        check("t6_ready_cnt4", iss_ready, 1'b0);
        tick();
        idle(1'b1);
        check("t6_drain_tag0", tag_MUL, 5'd2);
        tick();
        check("t6_drain_tag1", tag_MUL, 5'd3);
        tick();
        check("t6_drain_tag2", tag_MUL, 5'd4);
        tick();
        check("t6_drain_we3",  we_MUL,  1'b1);
        check("t6_drain_tag3", tag_MUL, 5'd21);
        check("t6_drain_val3", val_MUL, 32'd21);
        tick();
        check("t6_empty", we_MUL, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
